// File: rtl/game_pkg.sv
// Shared types and constants for the Simon game sequencer: state encoding,
// default round limits and the level-to-target mapping.
package game_pkg;

    typedef enum logic [2:0] {
        S_IDLE   = 3'd0,
        S_SHOW   = 3'd1,
        S_INPUT  = 3'd2,
        S_RESULT = 3'd3
    } game_state_t;

    localparam int DEF_ROUND_STEP = 8;
    localparam int DEF_MAX_ROUNDS = 32;

    // Rounds needed to win at a given level, never above the absolute ceiling
    function automatic int level_target(input logic [1:0] level, input int step, input int max_rounds);
        int t;
        t = step * (int'(level) + 1);
        if (t > max_rounds) begin
            return max_rounds;
        end else begin
            return t;
        end
    endfunction

endpackage

// File: rtl/game_sequencer_round_counter.sv
// Round counter for one game: clears at game start, steps on each good round,
// and flags when the next step reaches the latched target.
module round_counter #(
    parameter int ROUND_W = 6
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic               i_clear,
    input  logic               i_inc,
    input  logic [ROUND_W-1:0] i_target,
    output logic [ROUND_W-1:0] o_count,
    output logic               o_terminal
);

    logic [ROUND_W-1:0] r_count;
    logic [ROUND_W-1:0] w_next;

    assign w_next     = r_count + ROUND_W'(1'b1);
    assign o_terminal = (w_next == i_target);
    assign o_count    = r_count;

    // Count completed rounds; the target bound keeps the count from ever passing it
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_count <= '0;
        end else if (i_clear) begin
            r_count <= '0;
        end else if (i_inc && (r_count < i_target)) begin
            r_count <= w_next;
        end
    end

endmodule

// File: rtl/game_sequencer.sv
// Top-level Simon game sequencer: one phase enable at a time, win/lose decision.
// Optional INPUT-phase watchdog enabled by defining GAME_SEQ_WATCHDOG_EN.
module game_sequencer
    import game_pkg::*;
#(
    parameter int MAX_ROUNDS     = DEF_MAX_ROUNDS,
    parameter int TIMEOUT_CYCLES = 500_000_000,
    parameter int ROUND_STEP     = DEF_ROUND_STEP,
    localparam int ROUND_W       = $clog2(MAX_ROUNDS + 1)
) (
    input  logic               i_clk,
    input  logic               i_rst,
    input  logic [1:0]         i_level,
    input  logic               i_idle_done,
    input  logic               i_show_done,
    input  logic               i_input_done,
    input  logic               i_input_ok,
    input  logic               i_ack,
    output logic               o_idle_en,
    output logic               o_show_en,
    output logic               o_input_en,
    output logic               o_result_en,
    output logic [ROUND_W-1:0] o_round,
    output logic               o_win,
    output logic               o_lose,
    output logic [2:0]         o_state
);

    game_state_t        r_state;
    logic [ROUND_W-1:0] r_target;
    logic [ROUND_W-1:0] w_level_target;
    logic               w_clear;
    logic               w_inc;
    logic               w_terminal;
    logic               w_timeout;

    assign w_level_target = ROUND_W'(level_target(i_level, ROUND_STEP, MAX_ROUNDS));
    assign w_clear        = (r_state == S_IDLE) && i_idle_done;
    assign w_inc          = (r_state == S_INPUT) && i_input_done && i_input_ok;
    assign o_state        = r_state;

    round_counter #(.ROUND_W(ROUND_W)) u_round_counter (
        .i_clk      (i_clk),
        .i_rst      (i_rst),
        .i_clear    (w_clear),
        .i_inc      (w_inc),
        .i_target   (r_target),
        .o_count    (o_round),
        .o_terminal (w_terminal)
    );

`ifdef GAME_SEQ_WATCHDOG_EN
    localparam int WD_W = $clog2(TIMEOUT_CYCLES + 1);
    logic [WD_W-1:0] r_wd_cnt;

    assign w_timeout = (r_state == S_INPUT) && (r_wd_cnt == WD_W'(TIMEOUT_CYCLES - 1));

    // Cycles spent in INPUT; held at zero in every other state so each entry starts fresh
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_wd_cnt <= '0;
        end else if (r_state != S_INPUT) begin
            r_wd_cnt <= '0;
        end else begin
            r_wd_cnt <= r_wd_cnt + WD_W'(1'b1);
        end
    end
`else
    assign w_timeout = 1'b0;
`endif

    // Phase FSM; enables and result flags change on the same edge as the state
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state     <= S_IDLE;
            r_target    <= ROUND_W'(level_target(2'd0, ROUND_STEP, MAX_ROUNDS));
            o_win       <= 1'b0;
            o_lose      <= 1'b0;
            o_idle_en   <= 1'b1;
            o_show_en   <= 1'b0;
            o_input_en  <= 1'b0;
            o_result_en <= 1'b0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (i_idle_done) begin
                        r_target  <= w_level_target;
                        r_state   <= S_SHOW;
                        o_idle_en <= 1'b0;
                        o_show_en <= 1'b1;
                    end
                end
                S_SHOW: begin
                    if (i_show_done) begin
                        r_state    <= S_INPUT;
                        o_show_en  <= 1'b0;
                        o_input_en <= 1'b1;
                    end
                end
                S_INPUT: begin
                    // A real input always beats a same-cycle timeout
                    if (i_input_done) begin
                        o_input_en <= 1'b0;
                        if (!i_input_ok) begin
                            r_state     <= S_RESULT;
                            o_lose      <= 1'b1;
                            o_result_en <= 1'b1;
                        end else if (w_terminal) begin
                            r_state     <= S_RESULT;
                            o_win       <= 1'b1;
                            o_result_en <= 1'b1;
                        end else begin
                            r_state   <= S_SHOW;
                            o_show_en <= 1'b1;
                        end
                    end else if (w_timeout) begin
                        r_state     <= S_RESULT;
                        o_lose      <= 1'b1;
                        o_input_en  <= 1'b0;
                        o_result_en <= 1'b1;
                    end
                end
                S_RESULT: begin
                    if (i_ack) begin
                        r_state     <= S_IDLE;
                        o_win       <= 1'b0;
                        o_lose      <= 1'b0;
                        o_result_en <= 1'b0;
                        o_idle_en   <= 1'b1;
                    end
                end
                default: begin
                    r_state     <= S_IDLE;
                    o_win       <= 1'b0;
                    o_lose      <= 1'b0;
                    o_idle_en   <= 1'b1;
                    o_show_en   <= 1'b0;
                    o_input_en  <= 1'b0;
                    o_result_en <= 1'b0;
                end
            endcase
        end
    end

endmodule
